// File: rtl/rvfi_dmem_responder.sv
// Memory responder for a core's native memory port that keeps a byte-accurate shadow of one watched word.
// Define RVFI_DMEM_RESPONDER_WAIT_EN to insert up to MAX_WAIT stall cycles per transaction.
module rvfi_dmem_responder #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] free_rdata,
  input  logic        stall_req,
  output logic [31:0] dmem_data,
  output logic [3:0]  dmem_bvalid,
  output logic        protocol_err
);

  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        instr_q;
  logic        is_write, addr_match, req_changed, busy;
  logic [1:0]  unused_dmem_lsb;

  assign unused_dmem_lsb = dmem_addr[1:0];

  // A zero strobe is a read; matching is word-granular and only used at ACK.
  assign is_write    = |wstrb_q;
  assign addr_match  = (addr_q[31:2] == dmem_addr[31:2]);
  assign busy        = (state == WAIT) || (state == ACK);
  assign req_changed = !mem_valid || (mem_addr != addr_q) || (mem_wdata != wdata_q) ||
                       (mem_wstrb != wstrb_q) || (mem_instr != instr_q);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mem_valid) begin
`ifdef RVFI_DMEM_RESPONDER_WAIT_EN
          state_nxt = WAIT;
`else
          state_nxt = ACK;
`endif
        end
      end
      WAIT:    if (!stall_req || (wait_cnt == WAIT_LAST)) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read data: shadow bytes that are defined win, everything else comes from free_rdata.
  always_comb begin
    mem_ready = (state == ACK);
    mem_rdata = '0;
    if ((state == ACK) && !is_write) begin
      for (int i = 0; i < 4; i++) begin
        mem_rdata[8*i +: 8] = (addr_match && dmem_bvalid[i]) ? dmem_data[8*i +: 8]
                                                              : free_rdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      instr_q      <= 1'b0;
      dmem_data    <= '0;
      dmem_bvalid  <= '0;
      protocol_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && mem_valid) begin
        addr_q   <= mem_addr;
        wdata_q  <= mem_wdata;
        wstrb_q  <= mem_wstrb;
        instr_q  <= mem_instr;
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      if (busy && req_changed) protocol_err <= 1'b1;
      // Writes load strobed bytes; reads pin down bytes first observed via free_rdata.
      if ((state == ACK) && addr_match) begin
        for (int i = 0; i < 4; i++) begin
          if (is_write ? wstrb_q[i] : !dmem_bvalid[i]) begin
            dmem_data[8*i +: 8] <= is_write ? wdata_q[8*i +: 8] : free_rdata[8*i +: 8];
            dmem_bvalid[i]      <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rvfi_dmem_responder.sv
// Directed bench for rvfi_dmem_responder: transaction-level shadow model, per-cycle compare, literal pins.
module tb_rvfi_dmem_responder;

  localparam int MAX_WAIT = 4;
`ifdef RVFI_DMEM_RESPONDER_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] dmem_addr, free_rdata;
  logic        stall_req;
  logic [31:0] dmem_data;
  logic [3:0]  dmem_bvalid;
  logic        protocol_err;

  rvfi_dmem_responder #(.MAX_WAIT(MAX_WAIT)) dut (
    .clock(clock), .reset(reset),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .dmem_addr(dmem_addr), .free_rdata(free_rdata), .stall_req(stall_req),
    .dmem_data(dmem_data), .dmem_bvalid(dmem_bvalid), .protocol_err(protocol_err)
  );

  // Clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard and shadow model
  logic [31:0] exp_q[$];
  logic [7:0]  m_byte[4];
  bit          m_val[4];
  bit          exp_err;
  bit          chk_en;
  int          n_checks, n_fail;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word();
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = m_byte[i];
    return w;
  endfunction

  function automatic logic [31:0] model_bval();
    logic [31:0] b = '0;
    for (int i = 0; i < 4; i++) b[i] = m_val[i];
    return b;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [31:0] a, input logic [3:0] ws,
                                              input logic [31:0] fr);
    logic [31:0] r;
    if (ws != 4'h0) return 32'h0;
    if (a[31:2] != dmem_addr[31:2]) return fr;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = m_val[i] ? m_byte[i] : fr[8*i +: 8];
    return r;
  endfunction

  task automatic model_update(input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] ws, input logic [31:0] fr);
    if (a[31:2] == dmem_addr[31:2]) begin
      for (int i = 0; i < 4; i++) begin
        if (ws != 4'h0 && ws[i]) begin
          m_byte[i] = wd[8*i +: 8];
          m_val[i]  = 1'b1;
        end else if (ws == 4'h0 && !m_val[i]) begin
          m_byte[i] = fr[8*i +: 8];
          m_val[i]  = 1'b1;
        end
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_byte[i] = 8'h0;
      m_val[i]  = 1'b0;
    end
    exp_err = 1'b0;
    exp_q.delete();
  endtask

  // Per-cycle compare against the model
  always @(negedge clock) begin
    if (chk_en) begin
      if (mem_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rdata_unexpected: got ready with rdata 0x%08h, no transaction expected", mem_rdata);
        end else begin
          chk("rdata", mem_rdata, exp_q.pop_front());
        end
      end else begin
        chk("rdata_idle", mem_rdata, 32'h0);
      end
      chk("dmem_data", dmem_data, model_word());
      chk("dmem_bvalid", {28'h0, dmem_bvalid}, model_bval());
      chk("protocol_err", {31'h0, protocol_err}, {31'h0, exp_err});
    end
  end

  // Driver tasks
  task automatic do_reset();
    reset     = 1'b1;
    mem_valid = 1'b0;
    @(posedge clock); #1;
    model_clear();
    reset = 1'b0;
  endtask

  task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     input logic ins, input logic [31:0] fr, input logic st,
                     input bit rst_in_ack, output logic [31:0] got);
    int lat;
    int exp_lat;
    exp_lat = WAIT_EN ? (st ? MAX_WAIT + 1 : 2) : 1;
    exp_q.push_back(model_rdata(a, ws, fr));
    mem_addr   = a;
    mem_wdata  = wd;
    mem_wstrb  = ws;
    mem_instr  = ins;
    free_rdata = fr;
    stall_req  = st;
    mem_valid  = 1'b1;
    lat = 0;
    do begin
      @(posedge clock); #1;
      lat++;
    end while (!mem_ready && lat < 40);
    chk("latency", 32'(lat), 32'(exp_lat));
    got = mem_rdata;
    if (rst_in_ack) begin
      do_reset();
    end else begin
      @(posedge clock); #1;
      model_update(a, wd, ws, fr);
      mem_valid = 1'b0;
    end
  endtask

  // Unmatched read with a protocol violation injected right after the request is taken.
  task automatic proto(input bit drop_valid);
    exp_q.push_back(32'hA5A50F0F);
    mem_addr   = 32'h200;
    mem_wdata  = 32'h0;
    mem_wstrb  = 4'h0;
    mem_instr  = 1'b0;
    free_rdata = 32'hA5A50F0F;
    stall_req  = 1'b0;
    mem_valid  = 1'b1;
    @(posedge clock); #1;
    if (drop_valid) mem_valid = 1'b0;
    else            mem_addr  = 32'h204;
    @(posedge clock); #1;
    exp_err   = 1'b1;
    mem_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("err_sticky", {31'h0, protocol_err}, 32'h1);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
  endtask

  logic [31:0] got;

  initial begin
    chk_en     = 1'b0;
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    mem_valid  = 1'b0;
    mem_instr  = 1'b0;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    mem_wstrb  = 4'h0;
    dmem_addr  = 32'h100;
    free_rdata = 32'h0;
    stall_req  = 1'b0;
    model_clear();
    repeat (3) @(posedge clock);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    chk("reset_ready", {31'h0, mem_ready}, 32'h0);
    chk("reset_data", dmem_data, 32'h0);
    chk("reset_bvalid", {28'h0, dmem_bvalid}, 32'h0);
    chk("reset_err", {31'h0, protocol_err}, 32'h0);

    // Full write then read back
    txn(32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 32'h55555555, 1'b0, 1'b0, got);
    chk("write_rdata_zero", got, 32'h0);
    txn(32'h100, 32'h0, 4'h0, 1'b0, 32'h12345678, 1'b0, 1'b0, got);
    chk("full_rd", got, 32'hDEADBEEF);
    chk("full_bvalid", {28'h0, dmem_bvalid}, 32'hF);

    // Partial write, then reads fill and then freeze the missing bytes
    do_reset();
    txn(32'h102, 32'h00AA0000, 4'b0100, 1'b0, 32'h0, 1'b0, 1'b0, got);
    chk("partial_bvalid", {28'h0, dmem_bvalid}, 32'h4);
    txn(32'h100, 32'h0, 4'h0, 1'b0, 32'h11223344, 1'b0, 1'b0, got);
    chk("partial_rd1", got, 32'h11AA3344);
    txn(32'h100, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0, got);
    chk("partial_rd2", got, 32'h11AA3344);
    txn(32'h100, 32'h0, 4'h0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, got);
    chk("ifetch_rd", got, 32'h11AA3344);

    // Unmatched read passes free data through and leaves the shadow alone
    txn(32'h200, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, got);
    chk("unmatched_rd", got, 32'hCAFEF00D);
    chk("unmatched_data", dmem_data, 32'h11AA3344);
    chk("unmatched_bvalid", {28'h0, dmem_bvalid}, 32'hF);

    // Byte writes, an unmatched write, and a read at an unaligned matching address
    txn(32'h103, 32'h99000000, 4'b1000, 1'b0, 32'h0, 1'b1, 1'b0, got);
    chk("byte3_data", dmem_data, 32'h99AA3344);
    txn(32'h300, 32'h01020304, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0, got);
    chk("unmatched_wr_data", dmem_data, 32'h99AA3344);
    txn(32'h101, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 1'b0, got);
    chk("unaligned_rd", got, 32'h99AA3344);
    txn(32'h100, 32'h0000BEEF, 4'b0011, 1'b0, 32'h0, 1'b0, 1'b0, got);
    chk("low_half_data", dmem_data, 32'h99AABEEF);

    // Protocol violations, each cleared only by reset
    proto(1'b1);
    do_reset();
    chk("err_cleared1", {31'h0, protocol_err}, 32'h0);
    proto(1'b0);
    do_reset();
    chk("err_cleared2", {31'h0, protocol_err}, 32'h0);

    // Reset landing on the ACK of a write suppresses the merge
    txn(32'h100, 32'h0BADF00D, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0, got);
    chk("pre_rst_data", dmem_data, 32'h0BADF00D);
    txn(32'h100, 32'h12345678, 4'hF, 1'b0, 32'h0, 1'b0, 1'b1, got);
    chk("rst_ack_ready", {31'h0, mem_ready}, 32'h0);
    chk("rst_ack_data", dmem_data, 32'h0);
    chk("rst_ack_bvalid", {28'h0, dmem_bvalid}, 32'h0);
    txn(32'h100, 32'h0, 4'h0, 1'b0, 32'h00000077, 1'b0, 1'b0, got);
    chk("post_rst_rd", got, 32'h00000077);

    repeat (3) @(posedge clock);
    #1;
    chk("final_queue", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
